mult_feeder: RTL and testbench

- Upstream command stage for the 16x16 signed multiplier.
- Buffers operand pairs in a FIFO, generates operand parity (with optional error injection) and drives the multiplier req/ack handshake.
- Captures the multiplier result and status on result_rdy, checks result parity, and presents one response per command on a valid/ready output port, in command order.

---
 rtl/mult_feeder.sv | 182 ++++++++++++++++++
 tb/tb_mult_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_feeder.sv
// Command feeder for the 16x16 signed multiplier: operand FIFO, operand parity
// generation, req/ack sequencing with timeout, and an in-order response port.
module mult_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic [1:0]               in_inject,
  output logic                     req,
  output logic [15:0]              arg_a,
  output logic                     arg_a_parity,
  output logic [15:0]              arg_b,
  output logic                     arg_b_parity,
  input  logic                     ack,
  input  logic [31:0]              result,
  input  logic                     result_parity,
  input  logic                     result_rdy,
  input  logic                     arg_parity_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_par_err,
  output logic                     out_res_par_bad,
  output logic                     out_timeout,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RDY = 2'd2,
    S_OUT      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [33:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [33:0]     head;
  logic            push, pop, empty, timed_out;
  logic            capture, abort;

  logic [15:0]     arg_a_q, arg_b_q;
  logic            arg_a_par_q, arg_b_par_q;
  logic [31:0]     out_result_q;
  logic            out_par_err_q, out_res_par_bad_q, out_timeout_q;

  // Response port: a response transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid and every out_* field stay constant
  // from the cycle out_valid rises until that transfer.
  assign empty     = (level_q == '0);
  assign in_ready  = (level_q != LW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_inject, in_b, in_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = timed_out ? cnt_q : cnt_q + CW'(1);
        if (ack && result_rdy) begin
          capture = 1'b1;
          state_d = S_OUT;
        end else if (ack) begin
          state_d = S_WAIT_RDY;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_WAIT_RDY: begin
        cnt_d = timed_out ? cnt_q : cnt_q + CW'(1);
        if (result_rdy) begin
          capture = 1'b1;
          state_d = S_OUT;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        // Chain straight into the next command to avoid an IDLE bubble.
        if (out_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      arg_a_q           <= '0;
      arg_b_q           <= '0;
      arg_a_par_q       <= 1'b0;
      arg_b_par_q       <= 1'b0;
      out_result_q      <= '0;
      out_par_err_q     <= 1'b0;
      out_res_par_bad_q <= 1'b0;
      out_timeout_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        arg_a_q     <= head[15:0];
        arg_b_q     <= head[31:16];
        arg_a_par_q <= (^head[15:0])  ^ head[32];
        arg_b_par_q <= (^head[31:16]) ^ head[33];
      end
      if (capture) begin
        out_result_q      <= result;
        out_par_err_q     <= arg_parity_error;
        out_res_par_bad_q <= (result_parity != ^result);
        out_timeout_q     <= 1'b0;
      end else if (abort) begin
        out_result_q      <= '0;
        out_par_err_q     <= 1'b0;
        out_res_par_bad_q <= 1'b0;
        out_timeout_q     <= 1'b1;
      end
    end
  end

  assign req             = (state_q == S_REQ);
  assign out_valid       = (state_q == S_OUT);
  assign arg_a           = arg_a_q;
  assign arg_b           = arg_b_q;
  assign arg_a_parity    = arg_a_par_q;
  assign arg_b_parity    = arg_b_par_q;
  assign out_result      = out_result_q;
  assign out_par_err     = out_par_err_q;
  assign out_res_par_bad = out_res_par_bad_q;
  assign out_timeout     = out_timeout_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_mult_feeder.sv
// Bench for mult_feeder: directed vector table plus hand-written sequences for
// backpressure, timeout and mid-transaction reset, against a multiplier stub.
module tb_mult_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [1:0]  in_inject;
  logic        req;
  logic [15:0] arg_a, arg_b;
  logic        arg_a_parity, arg_b_parity;
  logic        ack;
  logic [31:0] result;
  logic        result_parity, result_rdy, arg_parity_error;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_par_err, out_res_par_bad, out_timeout;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  mult_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_inject(in_inject),
    .req(req), .arg_a(arg_a), .arg_a_parity(arg_a_parity), .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .ack(ack), .result(result), .result_parity(result_parity), .result_rdy(result_rdy),
    .arg_parity_error(arg_parity_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_par_err(out_par_err), .out_res_par_bad(out_res_par_bad), .out_timeout(out_timeout),
    .fifo_level(fifo_level)
  );

  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Multiplier stub: acks after ack_dly cycles, returns the product rdy_dly
  // cycles after the ack (0 = same cycle). stray_cnt requests a lone ack+rdy pulse.
  logic model_on = 1'b0;
  int   ack_dly = 1, rdy_dly = 1;
  logic bad_rp = 1'b0;
  int   stray_cnt = 0, stray_done = 0;
  int   m_phase = 0, m_cnt = 0;
  logic signed [31:0] m_prod;
  logic m_pe;

  initial begin
    ack = 1'b0; result_rdy = 1'b0; result = '0; result_parity = 1'b0; arg_parity_error = 1'b0;
  end

  always @(negedge clk) begin
    ack = 1'b0;
    result_rdy = 1'b0;
    if (stray_cnt != stray_done) begin
      stray_done++;
      ack = 1'b1;
      result_rdy = 1'b1;
      result = 32'h0000_1234;
      result_parity = 1'b1;
      arg_parity_error = 1'b0;
    end else begin
      case (m_phase)
        0: if (req && model_on) begin
             if (ack_dly == 0) m_cnt = 0;
             else begin m_cnt = ack_dly; m_phase = 1; end
           end
        1: m_cnt--;
        2: m_cnt--;
        default: m_phase = 0;
      endcase
      if ((m_phase == 0 && req && model_on && ack_dly == 0) || (m_phase == 1 && m_cnt == 0)) begin
        ack = 1'b1;
        m_prod = $signed(arg_a) * $signed(arg_b);
        m_pe = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
        if (rdy_dly == 0) m_phase = 3;
        else begin m_cnt = rdy_dly; m_phase = 2; end
      end
      if (m_phase == 3 || (m_phase == 2 && m_cnt == 0)) begin
        result_rdy = 1'b1;
        result = m_prod;
        result_parity = (^m_prod) ^ bad_rp;
        arg_parity_error = m_pe;
        m_phase = 0;
      end
    end
  end

  // Scoreboard: the transfer happens on the next rising edge after this sample.
  int n_resp = 0;
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response: got %0h, required none",
                 {out_timeout, out_res_par_bad, out_par_err, out_result});
      end else begin
        chk("response", {out_timeout, out_res_par_bad, out_par_err, out_result}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: %0d responses outstanding, required 0", name, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s: out_valid got 0, required 1 within 100 cycles", name);
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [1:0]  inj;
    int          ack_d, rdy_d;
    logic        brp;
    logic        exp_pa, exp_pb;
    logic [31:0] exp_res;
    logic        exp_pe, exp_rpb;
  } vec_t;

  vec_t tv[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int n;

    tv[0] = '{16'h0003, 16'hFFFE, 2'b00, 2, 1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0};
    tv[1] = '{16'h0001, 16'h0000, 2'b01, 1, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[2] = '{16'h0001, 16'h0001, 2'b00, 1, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
    tv[3] = '{16'h8000, 16'h8000, 2'b00, 1, 0, 1'b0, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b0};
    tv[4] = '{16'h7FFF, 16'hFFFF, 2'b10, 0, 3, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0};
    tv[5] = '{16'h1234, 16'h0010, 2'b11, 3, 1, 1'b0, 1'b0, 1'b0, 32'h0001_2340, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_inject = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_req", req, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_fifo_level", fifo_level, 0);
    chk("reset_arg_a", arg_a, 0);
    chk("reset_out_flags", {out_timeout, out_res_par_bad, out_par_err, out_result}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, one command at a time.
    model_on = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ack_dly = tv[i].ack_d;
      rdy_dly = tv[i].rdy_d;
      bad_rp  = tv[i].brp;
      in_a = tv[i].a; in_b = tv[i].b; in_inject = tv[i].inj; in_valid = 1'b1;
      exp_q.push_back({1'b0, tv[i].exp_rpb, tv[i].exp_pe, tv[i].exp_res});
      @(negedge clk);
      in_valid = 1'b0;
      chk("req_low_after_push", req, 0);
      chk("level_after_push", fifo_level, 1);
      @(negedge clk);
      chk("req_one_cycle_after_push", req, 1);
      chk("arg_a", arg_a, tv[i].a);
      chk("arg_b", arg_b, tv[i].b);
      chk("arg_a_parity", arg_a_parity, tv[i].exp_pa);
      chk("arg_b_parity", arg_b_parity, tv[i].exp_pb);
      wait_drain("vector_drain", 100);
    end
    bad_rp = 1'b0;

    // Backpressure: seven back-to-back pushes with the response port stalled.
    out_ready = 1'b0; ack_dly = 1; rdy_dly = 1; accepted = 0;
    for (int i = 0; i < 7; i++) begin
      in_a = 16'(i + 1); in_b = 16'(i + 10); in_inject = 2'b00; in_valid = 1'b1;
      if (in_ready) begin
        accepted++;
        exp_q.push_back({3'b000, 32'((i + 1) * (i + 10))});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_accepted", accepted, 5);
    chk("bp_fifo_level", fifo_level, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    chk("bp_out_result_held", out_result, 32'd10);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_out_valid("bp_response_wait");
      @(negedge clk);
      chk("bp_no_idle_bubble", req, 1);
    end
    wait_drain("bp_drain", 200);

    // Timeout: the stub never acknowledges.
    model_on = 1'b0; out_ready = 1'b0;
    in_a = 16'h0005; in_b = 16'h0005; in_inject = 2'b00; in_valid = 1'b1;
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!req && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (req && n < 400) begin @(negedge clk); n++; end
    chk("timeout_req_cycles", n, TIMEOUT);
    chk("timeout_out_valid", out_valid, 1);
    stray_cnt++;
    repeat (3) @(negedge clk);
    chk("timeout_late_rdy_result", out_result, 0);
    chk("timeout_flag_held", out_timeout, 1);
    out_ready = 1'b1;
    wait_drain("timeout_drain", 50);
    stray_cnt++;
    repeat (10) @(negedge clk);
    chk("idle_stray_out_valid", out_valid, 0);
    chk("idle_stray_req", req, 0);

    // Reset while a command waits for its result and two more are queued.
    model_on = 1'b1; ack_dly = 1; rdy_dly = 15; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'(i + 2); in_b = 16'(i + 3); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_req", req, 0);
    chk("pre_reset_level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", req, 0);
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_level", fifo_level, 0);
    chk("async_reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = n_resp;
    repeat (25) @(negedge clk);
    chk("post_reset_no_response", n_resp, n);
    chk("post_reset_out_valid", out_valid, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
